audrey_mix_sched: RTL and testbench
===================================

Name: audrey_mix_sched

Overview:
- Per-sample mix scheduler for the Audrey voice array.
- On each 48 kHz sample_strobe it snapshots all voice samples, then sequences them one per clock through a single shared signed multiply-accumulate unit, applying per-voice volume and mute.
- It then applies master volume, saturates to 16-bit signed and presents one mixed PCM sample with a valid pulse.
- It sits between the voice array and the DAC/I2S serialiser, so the design needs one multiplier instead of eight.

Parameters:
- NUM_VOICES, 8, number of voices sequenced per sample (1..8).
- SAMPLE_W, 16, voice and mix sample width (signed).
- VOL_W, 8, per-voice and master volume width (unsigned; 0 = silent, 255 = 255/256 gain).

Ports:
- clk  in  1  audio clock, 49.152 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sample_strobe  in  1  one-cycle pulse per 48 kHz period.
- voice_sample  in  NUM_VOICES*SAMPLE_W  packed signed voice outputs; voice i is at bits [i*16+15 : i*16].
- voice_vol  in  NUM_VOICES*VOL_W  packed per-voice volumes, same packing as voice_sample.
- voice_mute  in  NUM_VOICES  bit i = 1 mutes voice i.
- master_vol  in  VOL_W  master volume.
- overrun_clr  in  1  clears the overrun flag.
- mix_out  out  SAMPLE_W  mixed signed PCM sample; held between updates.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high while a mix is in progress (state != IDLE).
- overrun  out  1  sticky; set when a strobe arrives while busy.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: mix_out = 0, mix_valid = 0, busy = 0, overrun = 0.
  - Internal: state = IDLE, accumulator = 0, voice index = 0.
  - Deassertion takes effect on the next clk edge.
  - Reset mid-mix abandons the mix; no mix_valid is produced.
- FSM states: IDLE -> MAC -> MASTER -> SAT -> IDLE.
- IDLE:
  - On sample_strobe at edge N, register snapshots of voice_sample, voice_vol and voice_mute.
  - Clear the accumulator, set idx = 0, go to MAC.
- MAC, edges N+1 .. N+NUM_VOICES:
  - Each cycle: acc += mute[idx] ? 0 : sample[idx] * $signed({1'b0, vol[idx]}).
  - The product is 24-bit signed; the accumulator is 27-bit signed (no overflow possible).
  - idx increments each cycle; after the last voice, go to MASTER.
- MASTER, next edge:
  - pre = acc >>> 8 (arithmetic shift, floors toward -inf), 19-bit signed.
  - m = pre * $signed({1'b0, master_vol}), registered.
  - Go to SAT.
- SAT, next edge:
  - res = m >>> 8.
  - Clamp res to [-32768, +32767] and write it to mix_out.
  - mix_valid = 1 for this one cycle only; go to IDLE.
- Latency with NUM_VOICES = 8:
  - Strobe sampled at edge N -> mix_out and mix_valid update at edge N+10.
  - busy is high from edge N through edge N+10, then low.
- Snapshot: input changes after edge N do not affect the mix in progress. master_vol is sampled live in the MASTER state.
- Strobe while state != IDLE, including the SAT cycle:
  - The strobe is ignored and the mix in progress completes normally.
  - overrun is set.
- overrun is cleared by overrun_clr. If overrun_clr and an overrunning strobe occur in the same cycle, set wins.
- mix_out holds its value except in the SAT cycle. mix_valid is never high in two consecutive cycles.
- Nominal strobe spacing is 1024 clocks, so overrun indicates a system fault.

Decomposition:
- Shared package audrey_pkg holds:
  - Constants: AUDREY_NUM_VOICES, AUDREY_SAMPLE_W, AUDREY_VOL_W, MIX_ACC_W = 27.
  - Typedef: mix_state_t enum {IDLE, MAC, MASTER, SAT}.
- One sub-module, audrey_sat16: combinational clamp of a 19-bit signed value to 16-bit signed. It is reused later by the I2S path.

Test Plan:
- Single voice: voice0 = 0x7FF0, vol0 = 0xFF, others muted, master = 0xFF -> one mix_valid exactly 10 clocks after the strobe; mix_out = 0x7EF0 (32496).
- Positive saturation: all 8 voices 0x7FFF, vol 0xFF, master 0xFF -> mix_out = 0x7FFF. All 8 voices 0x8000 -> mix_out = 0x8000.
- Mute and zero volume:
  - All voices 0x4000, voice_mute = 0xFF -> mix_out = 0x0000 with mix_valid still pulsed.
  - Mute = 0x00 with master = 0x00 -> mix_out = 0x0000.
- Snapshot and overrun:
  - voice0 = 0x1000 (vol 0xFF, master 0xFF, others muted) at strobe; change it to 0x7000 at N+3 and strobe again at N+5.
  - Required: exactly one mix_valid, mix_out = 0x0FE0, overrun = 1.
  - overrun_clr then returns overrun to 0.
- Reset mid-mix: assert rst_n at N+4 -> mix_out = 0, busy = 0 immediately (asynchronous); no mix_valid. The next strobe after release produces a normal result.
- Negative rounding: voice0 = 0xFFFF (-1), vol 0x01, master 0xFF -> mix_out = 0xFFFF (floor behaviour of >>>).

Source files
------------

// File: rtl/audrey_pkg.sv
// Shared constants and state encoding for the Audrey mix path.
package audrey_pkg;

  localparam int unsigned AUDREY_NUM_VOICES = 8;
  localparam int unsigned AUDREY_SAMPLE_W   = 16;
  localparam int unsigned AUDREY_VOL_W      = 8;
  localparam int unsigned MIX_ACC_W         = 27;
  // Accumulator after the >>> 8 volume normalisation.
  localparam int unsigned MIX_PRE_W         = MIX_ACC_W - AUDREY_VOL_W;
  // Master product: 19-bit pre times 9-bit unsigned gain always fits in 27 bits.
  localparam int unsigned MIX_MST_W         = MIX_PRE_W + AUDREY_VOL_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    MASTER,
    SAT
  } mix_state_t;

endpackage

// File: rtl/audrey_sat16.sv
// Combinational clamp of a 19-bit signed value into the 16-bit signed PCM range.
module audrey_sat16
  import audrey_pkg::*;
(
  input  logic signed [MIX_PRE_W-1:0]       din,
  output logic signed [AUDREY_SAMPLE_W-1:0] dout_c
);

  localparam int unsigned MSB = MIX_PRE_W - 1;
  localparam int unsigned KW  = MIX_PRE_W - AUDREY_SAMPLE_W + 1;

  logic [KW-1:0] top_bits;
  logic          in_range;

  // In range when every bit from the output sign bit upward matches the input sign.
  always_comb begin
    top_bits = din[MSB -: KW];
    in_range = (top_bits == '0) || (top_bits == '1);
    if (in_range) begin
      dout_c = din[AUDREY_SAMPLE_W-1:0];
    end else begin
      dout_c = {din[MSB], {(AUDREY_SAMPLE_W-1){~din[MSB]}}};
    end
  end

endmodule

// File: rtl/audrey_mix_sched.sv
// Per-sample mix scheduler: snapshots all voices on a strobe, runs them through one
// shared MAC, applies master volume, saturates and emits one PCM sample.
module audrey_mix_sched
  import audrey_pkg::*;
#(
  parameter int unsigned NUM_VOICES = AUDREY_NUM_VOICES,
  parameter int unsigned SAMPLE_W   = AUDREY_SAMPLE_W,
  parameter int unsigned VOL_W      = AUDREY_VOL_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_strobe,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES*VOL_W-1:0]    voice_vol,
  input  logic [NUM_VOICES-1:0]          voice_mute,
  input  logic [VOL_W-1:0]               master_vol,
  input  logic                           overrun_clr,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           mix_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned PROD_W   = SAMPLE_W + VOL_W;
  localparam int unsigned LAST_IDX = NUM_VOICES - 1;

  mix_state_t                     state_q, state_d;
  logic [NUM_VOICES*SAMPLE_W-1:0] snap_sample_q, snap_sample_d;
  logic [NUM_VOICES*VOL_W-1:0]    snap_vol_q, snap_vol_d;
  logic [NUM_VOICES-1:0]          snap_mute_q, snap_mute_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [MIX_ACC_W-1:0]    acc_q, acc_d;
  logic signed [MIX_MST_W-1:0]    m_q, m_d;
  logic [SAMPLE_W-1:0]            mix_out_q, mix_out_d;
  logic                           mix_valid_q, mix_valid_d;
  logic                           busy_q, busy_d;
  logic                           overrun_q, overrun_d;

  logic signed [SAMPLE_W-1:0]     cur_sample_c;
  logic [VOL_W-1:0]               cur_vol_c;
  logic                           cur_mute_c;
  logic signed [PROD_W-1:0]       prod_c;
  logic signed [MIX_PRE_W-1:0]    pre_c;
  logic signed [MIX_PRE_W-1:0]    res_c;
  logic signed [SAMPLE_W-1:0]     sat_c;
  logic                           unused_c;

  // Select the snapshotted voice addressed by the sequencing index.
  always_comb begin
    cur_sample_c = '0;
    cur_vol_c    = '0;
    cur_mute_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_sample_c = snap_sample_q[i*SAMPLE_W +: SAMPLE_W];
        cur_vol_c    = snap_vol_q[i*VOL_W +: VOL_W];
        cur_mute_c   = snap_mute_q[i];
      end
    end
  end

  // Volumes are unsigned gains, so they enter the signed product with a zero sign bit.
  always_comb begin
    prod_c   = PROD_W'(cur_sample_c) * PROD_W'($signed({1'b0, cur_vol_c}));
    pre_c    = acc_q[MIX_ACC_W-1 -: MIX_PRE_W];
    res_c    = m_q[MIX_MST_W-1 -: MIX_PRE_W];
    unused_c = ^m_q[VOL_W-1:0];
  end

  audrey_sat16 u_sat (
    .din    (res_c),
    .dout_c (sat_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    snap_sample_d = snap_sample_q;
    snap_vol_d    = snap_vol_q;
    snap_mute_d   = snap_mute_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    m_d           = m_q;
    mix_out_d     = mix_out_q;
    mix_valid_d   = 1'b0;
    overrun_d     = overrun_q;

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (sample_strobe && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          snap_sample_d = voice_sample;
          snap_vol_d    = voice_vol;
          snap_mute_d   = voice_mute;
          acc_d         = '0;
          idx_d         = '0;
          state_d       = MAC;
        end
      end
      MAC: begin
        if (!cur_mute_c) begin
          acc_d = acc_q + MIX_ACC_W'(prod_c);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LAST_IDX)) begin
          idx_d   = '0;
          state_d = MASTER;
        end
      end
      MASTER: begin
        m_d     = MIX_MST_W'(pre_c) * MIX_MST_W'($signed({1'b0, master_vol}));
        state_d = SAT;
      end
      SAT: begin
        mix_out_d   = sat_c;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      snap_sample_q <= '0;
      snap_vol_q    <= '0;
      snap_mute_q   <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      m_q           <= '0;
      mix_out_q     <= '0;
      mix_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_sample_q <= snap_sample_d;
      snap_vol_q    <= snap_vol_d;
      snap_mute_q   <= snap_mute_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      m_q           <= m_d;
      mix_out_q     <= mix_out_d;
      mix_valid_q   <= mix_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audrey_mix_sched.sv
// Self-checking bench for audrey_mix_sched: directed vector table, multi-cycle
// corner sequences and randomized mixes against an arithmetic reference model.
module tb_audrey_mix_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sample_strobe;
  logic [127:0] voice_sample;
  logic [63:0]  voice_vol;
  logic [7:0]   voice_mute;
  logic [7:0]   master_vol;
  logic         overrun_clr;
  logic [15:0]  mix_out;
  logic         mix_valid;
  logic         busy;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] vs;
    logic [63:0]  vv;
    logic [7:0]   mu;
    logic [7:0]   mv;
    logic [15:0]  exp;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  audrey_mix_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .voice_sample  (voice_sample),
    .voice_vol     (voice_vol),
    .voice_mute    (voice_mute),
    .master_vol    (master_vol),
    .overrun_clr   (overrun_clr),
    .mix_out       (mix_out),
    .mix_valid     (mix_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Floor division by 256, written out explicitly rather than as a shift.
  function automatic longint floor_div256(input longint x);
    longint q;
    q = x / 256;
    if ((x % 256) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  // Reference: gain-weighted voice sum, two normalising floors, clamp to int16.
  function automatic logic [15:0] ref_mix(input logic [127:0] vs, input logic [63:0] vv,
                                          input logic [7:0] mu, input logic [7:0] mv);
    longint acc;
    longint r;
    logic [15:0] s;
    logic [7:0]  g;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      s = vs[i*16 +: 16];
      g = vv[i*8 +: 8];
      if (!mu[i]) acc = acc + longint'($signed(s)) * longint'(g);
    end
    r = floor_div256(floor_div256(acc) * longint'(mv));
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present inputs and strobe; returns at the falling edge after the strobe edge N.
  task automatic start_mix(input logic [127:0] vs, input logic [63:0] vv,
                           input logic [7:0] mu, input logic [7:0] mv);
    @(negedge clk);
    voice_sample  = vs;
    voice_vol     = vv;
    voice_mute    = mu;
    master_vol    = mv;
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic run_mix(input logic [127:0] vs, input logic [63:0] vv, input logic [7:0] mu,
                         input logic [7:0] mv, input logic [15:0] exp, input bit scramble,
                         input string name);
    int cyc;
    bit busy_bad;
    start_mix(vs, vv, mu, mv);
    cyc      = 0;
    busy_bad = 1'b0;
    while (!mix_valid && cyc < 20) begin
      if (!busy) busy_bad = 1'b1;
      if (scramble && cyc == 2) begin
        voice_sample = rand128();
        voice_vol    = {$urandom(), $urandom()};
        voice_mute   = 8'($urandom());
      end
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, 10);
    check({name, " mix_out"}, mix_out, exp);
    check({name, " busy during mix"}, busy_bad, 0);
    check({name, " busy after mix"}, busy, 0);
    @(negedge clk);
    check({name, " valid one cycle"}, mix_valid, 0);
  endtask

  initial begin
    int nvalid;
    int vcyc;
    logic [127:0] rvs;
    logic [63:0]  rvv;
    logic [7:0]   rmu;
    logic [7:0]   rmv;

    vecs[0] = '{{{7{16'h1234}}, 16'h7FF0}, {8{8'hFF}}, 8'hFE, 8'hFF, 16'h7EF0};
    vecs[1] = '{{8{16'h7FFF}}, {8{8'hFF}}, 8'h00, 8'hFF, 16'h7FFF};
    vecs[2] = '{{8{16'h8000}}, {8{8'hFF}}, 8'h00, 8'hFF, 16'h8000};
    vecs[3] = '{{8{16'h4000}}, {8{8'hFF}}, 8'hFF, 8'hFF, 16'h0000};
    vecs[4] = '{{8{16'h4000}}, {8{8'hFF}}, 8'h00, 8'h00, 16'h0000};
    vecs[5] = '{{{7{16'h5555}}, 16'hFFFF}, {{7{8'hFF}}, 8'h01}, 8'hFE, 8'hFF, 16'hFFFF};
    vecs[6] = '{{{7{16'h2222}}, 16'h1000}, {8{8'hFF}}, 8'hFE, 8'hFF, 16'h0FE0};
    vecs[7] = '{{{6{16'h7777}}, 16'hFF00, 16'h0100}, {{6{8'hFF}}, 8'h40, 8'h80}, 8'hFC, 8'h80, 16'h0020};
    vecs[8] = '{{{7{16'h0000}}, 16'h8000}, {{7{8'h00}}, 8'h80}, 8'hFE, 8'h80, 16'hE000};

    rst_n         = 1'b0;
    sample_strobe = 1'b0;
    voice_sample  = '0;
    voice_vol     = '0;
    voice_mute    = '0;
    master_vol    = '0;
    overrun_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset mix_out", mix_out, 0);
    check("reset mix_valid", mix_valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      run_mix(vecs[k].vs, vecs[k].vv, vecs[k].mu, vecs[k].mv, vecs[k].exp, 1'b0,
              $sformatf("vec%0d", k));
    end

    // Input change mid-mix plus an overrunning strobe at N+5.
    start_mix(vecs[6].vs, vecs[6].vv, vecs[6].mu, vecs[6].mv);
    nvalid = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mix_valid) nvalid++;
      if (c == 3) voice_sample[15:0] = 16'h7000;
      if (c == 4) sample_strobe = 1'b1;
      if (c == 5) sample_strobe = 1'b0;
    end
    check("snapshot valid count", nvalid, 1);
    check("snapshot mix_out", mix_out, 16'h0FE0);
    check("snapshot overrun set", overrun, 1);
    check("snapshot no restart", busy, 0);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun cleared", overrun, 0);

    // Strobe during SAT, with overrun_clr in the same cycle.
    start_mix(vecs[0].vs, vecs[0].vv, vecs[0].mu, vecs[0].mv);
    nvalid = 0;
    vcyc   = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mix_valid) begin
        nvalid++;
        vcyc = c;
      end
      if (c == 9) begin
        sample_strobe = 1'b1;
        overrun_clr   = 1'b1;
      end
      if (c == 10) begin
        sample_strobe = 1'b0;
        overrun_clr   = 1'b0;
      end
    end
    check("sat strobe valid count", nvalid, 1);
    check("sat strobe valid cycle", vcyc, 10);
    check("sat strobe mix_out", mix_out, 16'h7EF0);
    check("set beats clear", overrun, 1);
    check("sat strobe ignored", busy, 0);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun cleared again", overrun, 0);

    // Asynchronous reset in the middle of a mix.
    start_mix(vecs[5].vs, vecs[5].vv, vecs[5].mu, vecs[5].mv);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset mix_out", mix_out, 0);
    check("midreset busy", busy, 0);
    check("midreset mix_valid", mix_valid, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (mix_valid) nvalid++;
    end
    check("midreset no valid", nvalid, 0);
    run_mix(vecs[6].vs, vecs[6].vv, vecs[6].mu, vecs[6].mv, vecs[6].exp, 1'b0, "post reset");

    // Randomized mixes; inputs scrambled mid-mix to exercise the snapshot.
    for (int k = 0; k < 40; k++) begin
      rvs = rand128();
      rvv = {$urandom(), $urandom()};
      rmu = 8'($urandom());
      rmv = 8'($urandom());
      if (k % 4 == 0) begin
        rvv = {8{8'hFF}};
        rmv = 8'hFF;
        rmu = 8'h00;
      end
      run_mix(rvs, rvv, rmu, rmv, ref_mix(rvs, rvv, rmu, rmv), 1'b1,
              $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
